// File: rtl/game_pkg.sv
// Types shared by the input conditioner, player_controller and the map/collision logic.
package game_pkg;

    typedef enum logic [2:0] {
        DIR_NONE,
        DIR_UP,
        DIR_DOWN,
        DIR_LEFT,
        DIR_RIGHT
    } dir_t;

    localparam int GRID_STEP = 16;

    // Fixed priority up > down > left > right; bit order is {right, left, down, up}.
    function automatic dir_t prio_dir(input logic [3:0] v);
        dir_t d;
        d = DIR_NONE;
        if (v[0])      d = DIR_UP;
        else if (v[1]) d = DIR_DOWN;
        else if (v[2]) d = DIR_LEFT;
        else if (v[3]) d = DIR_RIGHT;
        return d;
    endfunction

endpackage

// File: rtl/button_debouncer.sv
// Two-flop synchroniser plus stable-level debouncer for one raw button, with a one-cycle rise strobe.
module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 650000
) (
    input  logic vclk,
    input  logic reset,
    input  logic btn,
    output logic db,
    output logic rise
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_reg;
    logic             sync2_reg;
    logic             db_reg;
    logic             rise_reg;
    logic [CNT_W-1:0] cnt_reg;

    always_ff @(posedge vclk or negedge reset) begin
        if (!reset) begin
            sync1_reg <= 1'b0;
            sync2_reg <= 1'b0;
            db_reg    <= 1'b0;
            rise_reg  <= 1'b0;
            cnt_reg   <= '0;
        end else begin
            sync1_reg <= btn;
            sync2_reg <= sync1_reg;
            rise_reg  <= 1'b0;
            if (sync2_reg == db_reg) begin
                cnt_reg <= '0;
            end else if (cnt_reg == CNT_LAST) begin
                // Level has differed for the full window: accept it.
                db_reg   <= sync2_reg;
                rise_reg <= sync2_reg;
                cnt_reg  <= '0;
            end else begin
                cnt_reg <= cnt_reg + CNT_W'(1);
            end
        end
    end

    assign db   = db_reg;
    assign rise = rise_reg;

endmodule

// File: rtl/move_input_conditioner.sv
// Turns four raw direction buttons into frame-aligned, single-direction move commands with tap latch and auto-repeat.
module move_input_conditioner
    import game_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES     = 650000,
    parameter int FIRST_REPEAT_FRAMES = 20,
    parameter int REPEAT_FRAMES       = 8
) (
    input  logic        vclk,
    input  logic        reset,
    input  logic [10:0] hcount,
    input  logic [9:0]  vcount,
    input  logic        btn_up,
    input  logic        btn_down,
    input  logic        btn_left,
    input  logic        btn_right,
    output logic        up,
    output logic        down,
    output logic        left,
    output logic        right,
    output logic        busy
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_FIRST  = 2'd1;
    localparam logic [1:0] ST_REPEAT = 2'd2;

    localparam int MAX_FRAMES = (FIRST_REPEAT_FRAMES > REPEAT_FRAMES) ? FIRST_REPEAT_FRAMES : REPEAT_FRAMES;
    localparam int FCNT_W     = (MAX_FRAMES > 1) ? $clog2(MAX_FRAMES) : 1;
    localparam logic [FCNT_W-1:0] FIRST_LAST  = FCNT_W'(FIRST_REPEAT_FRAMES - 1);
    localparam logic [FCNT_W-1:0] REPEAT_LAST = FCNT_W'(REPEAT_FRAMES - 1);

    logic              tick;
    logic [3:0]        btn_raw;
    logic [3:0]        db;
    logic [3:0]        rise;
    dir_t              held_dir;
    dir_t              emit_dir;
    dir_t              pending_reg, pending_next;
    dir_t              last_reg, last_next;
    logic [1:0]        state_reg, state_next;
    logic [FCNT_W-1:0] fcnt_reg, fcnt_next, fcnt_last;

    assign tick    = (hcount == '0) && (vcount == '0);
    assign btn_raw = {btn_right, btn_left, btn_down, btn_up};

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_btn
            button_debouncer #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_debouncer (
                .vclk  (vclk),
                .reset (reset),
                .btn   (btn_raw[gi]),
                .db    (db[gi]),
                .rise  (rise[gi])
            );
        end
    endgenerate

    assign held_dir = prio_dir(db);

    // A fresh edge wins over the tick clear so a press landing on a tick is kept for the next one.
    always_comb begin
        pending_next = pending_reg;
        if (|rise)     pending_next = prio_dir(rise);
        else if (tick) pending_next = DIR_NONE;
    end

    always_comb begin
        state_next = state_reg;
        fcnt_next  = fcnt_reg;
        last_next  = last_reg;
        emit_dir   = DIR_NONE;
        fcnt_last  = (state_reg == ST_REPEAT) ? REPEAT_LAST : FIRST_LAST;
        if (state_reg == ST_IDLE) begin
            if (pending_reg != DIR_NONE || held_dir != DIR_NONE) begin
                emit_dir   = (pending_reg != DIR_NONE) ? pending_reg : held_dir;
                state_next = ST_FIRST;
                fcnt_next  = '0;
            end
        end else if (pending_reg != DIR_NONE && pending_reg != last_reg) begin
            emit_dir   = pending_reg;
            state_next = ST_FIRST;
            fcnt_next  = '0;
        end else if (held_dir == DIR_NONE) begin
            state_next = ST_IDLE;
            fcnt_next  = '0;
        end else if (fcnt_reg == fcnt_last) begin
            emit_dir   = held_dir;
            state_next = ST_REPEAT;
            fcnt_next  = '0;
        end else begin
            fcnt_next = fcnt_reg + FCNT_W'(1);
        end
        if (emit_dir != DIR_NONE) last_next = emit_dir;
    end

    always_ff @(posedge vclk or negedge reset) begin
        if (!reset) begin
            pending_reg <= DIR_NONE;
            last_reg    <= DIR_NONE;
            state_reg   <= ST_IDLE;
            fcnt_reg    <= '0;
            up          <= 1'b0;
            down        <= 1'b0;
            left        <= 1'b0;
            right       <= 1'b0;
        end else begin
            pending_reg <= pending_next;
            if (tick) begin
                state_reg <= state_next;
                fcnt_reg  <= fcnt_next;
                last_reg  <= last_next;
                up        <= (emit_dir == DIR_UP);
                down      <= (emit_dir == DIR_DOWN);
                left      <= (emit_dir == DIR_LEFT);
                right     <= (emit_dir == DIR_RIGHT);
            end
        end
    end

    assign busy = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_move_input_conditioner.sv
// Directed and randomized bench for move_input_conditioner against a rule-level reference model.
module tb_move_input_conditioner;

    localparam int DEB   = 4;
    localparam int FRF   = 3;
    localparam int RPF   = 2;
    localparam int H     = 8;
    localparam int V     = 3;
    localparam int FRAME = H * V;

    logic        vclk = 1'b0;
    logic        reset = 1'b0;
    logic [10:0] hcount = '0;
    logic [9:0]  vcount = '0;
    logic        btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
    logic        up, down, left, right, busy;

    move_input_conditioner #(
        .DEBOUNCE_CYCLES     (DEB),
        .FIRST_REPEAT_FRAMES (FRF),
        .REPEAT_FRAMES       (RPF)
    ) dut (
        .vclk      (vclk),
        .reset     (reset),
        .hcount    (hcount),
        .vcount    (vcount),
        .btn_up    (btn_up),
        .btn_down  (btn_down),
        .btn_left  (btn_left),
        .btn_right (btn_right),
        .up        (up),
        .down      (down),
        .left      (left),
        .right     (right),
        .busy      (busy)
    );

    initial forever #5 vclk = ~vclk;

    int checks = 0;
    int errors = 0;
    int pos = 0;
    int frame_no = 0;
    int emit_cnt[4];
    int high_cycles[4];
    int last_emit_frame[4];
    int rf_q[$];

    // Reference model state: raw sample history, debounced levels, tap latch and repeat bookkeeping.
    logic [3:0] m_raw_q[$];
    logic [3:0] m_db, m_rise, m_out;
    int         m_pend, m_last, m_since;
    bit         m_active, m_rep;

    function automatic int prio4(input logic [3:0] v);
        for (int i = 0; i < 4; i++) if (v[i]) return i + 1;
        return 0;
    endfunction

    function automatic void model_reset();
        m_raw_q.delete();
        m_db = '0; m_rise = '0; m_out = '0;
        m_pend = 0; m_last = 0; m_since = 0;
        m_active = 0; m_rep = 0;
    endfunction

    function automatic void model_edge(input logic [3:0] r, input bit tick);
        int k, held, emit, idx;
        logic [3:0] db_new, s;
        bit all_diff;
        k = m_raw_q.size();
        held = prio4(m_db);
        db_new = m_db;
        // A level flips once the last DEB synchronised samples (raw delayed by two) all disagree with it.
        for (int i = 0; i < 4; i++) begin
            all_diff = 1;
            for (int j = 0; j < DEB; j++) begin
                idx = k - 2 - j;
                s = (idx >= 0) ? m_raw_q[idx] : 4'b0;
                if (s[i] == m_db[i]) all_diff = 0;
            end
            if (all_diff) db_new[i] = ~m_db[i];
        end
        m_raw_q.push_back(r);
        if (tick) begin
            emit = 0;
            if (!m_active) begin
                emit = (m_pend != 0) ? m_pend : held;
                if (emit != 0) begin m_active = 1; m_rep = 0; m_since = 0; end
            end else if (m_pend != 0 && m_pend != m_last) begin
                emit = m_pend; m_rep = 0; m_since = 0;
            end else if (held == 0) begin
                m_active = 0;
            end else begin
                m_since++;
                if (m_since == (m_rep ? RPF : FRF)) begin emit = held; m_rep = 1; m_since = 0; end
            end
            if (emit != 0) m_last = emit;
            m_out = (emit != 0) ? 4'(1 << (emit - 1)) : 4'b0;
        end
        if (m_rise != 0) m_pend = prio4(m_rise);
        else if (tick)   m_pend = 0;
        m_rise = db_new & ~m_db;
        m_db = db_new;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_stats();
        for (int i = 0; i < 4; i++) begin emit_cnt[i] = 0; high_cycles[i] = 0; last_emit_frame[i] = -1; end
        rf_q.delete();
    endtask

    // One clock: apply inputs at the falling edge, step the model at the rising edge, compare at the next falling edge.
    task automatic cycle(input logic [3:0] b);
        logic [3:0] o;
        {btn_right, btn_left, btn_down, btn_up} = b;
        hcount = 11'(pos % H);
        vcount = 10'(pos / H);
        @(posedge vclk);
        model_edge(b, pos == 0);
        @(negedge vclk);
        o = {right, left, down, up};
        check("outputs", 32'({busy, o}), 32'({m_active, m_out}));
        if (pos == 0) begin
            frame_no++;
            for (int i = 0; i < 4; i++) if (o[i]) begin
                emit_cnt[i]++;
                last_emit_frame[i] = frame_no;
                if (i == 3) rf_q.push_back(frame_no);
                $display("cmd frame %0d dir_onehot %b busy %b", frame_no, o, busy);
            end
        end
        for (int i = 0; i < 4; i++) if (o[i]) high_cycles[i]++;
        pos = (pos + 1) % FRAME;
    endtask

    task automatic pulse_reset(input int n);
        #2 reset = 1'b0;
        #1 check("async_reset", 32'({busy, right, left, down, up}), 32'd0);
        model_reset();
        repeat (n) begin
            hcount = 11'(pos % H);
            vcount = 10'(pos / H);
            @(posedge vclk);
            @(negedge vclk);
            pos = (pos + 1) % FRAME;
        end
        reset = 1'b1;
    endtask

    initial begin
        int n, t0;
        int exp_off[5];
        logic [3:0] b;
        exp_off = '{0, 3, 5, 7, 9};
        model_reset();
        clear_stats();

        // Reset state
        repeat (2) @(negedge vclk);
        check("reset_state", 32'({busy, right, left, down, up}), 32'd0);
        reset = 1'b1;

        // 1. Bounce shorter than the debounce window
        for (int i = 0; i < 20; i++) cycle({3'b000, 1'((i / 2) % 2)});
        repeat (3 * FRAME) cycle(4'b0000);
        check("bounce_db_up", 32'(dut.g_btn[0].u_debouncer.db), 32'd0);
        check("bounce_no_cmd", 32'(emit_cnt[0] + emit_cnt[1] + emit_cnt[2] + emit_cnt[3]), 32'd0);

        // 2. Short tap mid-frame
        while (pos != 8) cycle(4'b0000);
        clear_stats();
        repeat (8) cycle(4'b0100);
        repeat (3 * FRAME) cycle(4'b0000);
        check("tap_left_count", 32'(emit_cnt[2]), 32'd1);
        check("tap_left_width", 32'(high_cycles[2]), 32'(FRAME));
        check("tap_others", 32'(emit_cnt[0] + emit_cnt[1] + emit_cnt[3]), 32'd0);

        // 3. Continuous hold cadence
        clear_stats();
        n = 0;
        while (rf_q.size() == 0 && n < 4 * FRAME) begin cycle(4'b1000); n++; end
        check("hold_start", 32'(rf_q.size() != 0), 32'd1);
        t0 = (rf_q.size() != 0) ? rf_q[0] : frame_no;
        n = 0;
        while (frame_no < t0 + 10 && n < 12 * FRAME) begin cycle(4'b1000); n++; end
        repeat (3 * FRAME) cycle(4'b0000);
        check("hold_count", 32'(rf_q.size()), 32'd5);
        for (int i = 0; i < 5; i++)
            check("hold_offset", 32'((i < rf_q.size()) ? rf_q[i] - t0 : -1), 32'(exp_off[i]));

        // 4. Simultaneous up and right
        clear_stats();
        n = 0;
        while (emit_cnt[0] == 0 && n < 4 * FRAME) begin cycle(4'b1001); n++; end
        check("simul_up_first", 32'(emit_cnt[0]), 32'd1);
        check("simul_no_right", 32'(emit_cnt[3]), 32'd0);
        repeat (5 * FRAME) cycle(4'b1000);
        check("simul_up_once", 32'(emit_cnt[0]), 32'd1);
        check("simul_right_after", 32'(emit_cnt[3] != 0), 32'd1);
        repeat (2 * FRAME) cycle(4'b0000);

        // 5. Direction change restarts the repeat count
        clear_stats();
        n = 0;
        while (emit_cnt[1] == 0 && n < 4 * FRAME) begin cycle(4'b0010); n++; end
        t0 = last_emit_frame[1];
        repeat (FRAME) cycle(4'b0010);
        repeat (8) cycle(4'b0110);
        n = 0;
        while (frame_no < t0 + 5 && n < 8 * FRAME) begin cycle(4'b0010); n++; end
        check("change_left_once", 32'(emit_cnt[2]), 32'd1);
        check("change_left_frame", 32'(last_emit_frame[2] - t0), 32'd2);
        check("change_down_restart", 32'(last_emit_frame[1] - t0), 32'd5);
        repeat (2 * FRAME) cycle(4'b0000);

        // 6. Reset while repeating
        clear_stats();
        n = 0;
        while (emit_cnt[3] < 2 && n < 8 * FRAME) begin cycle(4'b1000); n++; end
        repeat (5) cycle(4'b1000);
        check("repeat_right_high", 32'({busy, right}), 32'b11);
        pulse_reset(3);
        n = 0;
        while (emit_cnt[3] < 3 && n < 4 * FRAME) begin cycle(4'b1000); n++; end
        check("post_reset_cmd", 32'(emit_cnt[3]), 32'd3);
        check("post_reset_delay", 32'(n >= DEB + 2), 32'd1);
        repeat (2 * FRAME) cycle(4'b0000);

        // Randomized segments
        for (int seg = 0; seg < 150; seg++) begin
            case ($urandom_range(0, 2))
                0:       b = 4'b0000;
                1:       b = 4'(1 << $urandom_range(0, 3));
                default: b = 4'($urandom_range(0, 15));
            endcase
            n = $urandom_range(1, 40);
            repeat (n) cycle(b);
            if ($urandom_range(0, 29) == 0) pulse_reset(2);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/move_input_conditioner.md
# move_input_conditioner

Conditions the four raw board direction buttons into clean, frame-aligned, single-direction move commands for `player_controller`, which samples its `up`/`down`/`left`/`right` inputs on the frame-start cycle (`hcount==0 && vcount==0`). The block synchronises, debounces, arbitrates to one direction, latches short taps, and auto-repeats held buttons. It sits between the board button pins and `player_controller`, in the `vclk` domain.

## Interface

Parameters:
- `DEBOUNCE_CYCLES`, 650000: consecutive stable `vclk` cycles required to accept a button level change (about 10 ms at 65 MHz).
- `FIRST_REPEAT_FRAMES`, 20: frames from the initial move to the first auto-repeat.
- `REPEAT_FRAMES`, 8: frames between later auto-repeats.

Ports:
- `vclk`, input, 1: pixel clock; the only clock.
- `reset`, input, 1: asynchronous, active-low reset.
- `hcount`, input, 11: current pixel column.
- `vcount`, input, 10: current line.
- `btn_up`, `btn_down`, `btn_left`, `btn_right`, input, 1 each: raw, asynchronous, active-high buttons.
- `up`, `down`, `left`, `right`, output, 1 each: registered move command, at most one high.
- `busy`, output, 1: high whenever the FSM is not IDLE.

## Operation

- **Frame tick.** `tick = (hcount==0 && vcount==0)`. The tick is decoded combinationally but used only as a register enable.
- **Synchroniser.** Each button passes through a 2-flop synchroniser.
- **Debounce, per button.**
  - The debounced level `db_x` changes only after the synchronised input has differed from `db_x` for exactly `DEBOUNCE_CYCLES` consecutive cycles.
  - Any return to the old level clears that button's counter.
  - Counter width is `$clog2(DEBOUNCE_CYCLES+1)`.
- **Arbitration.** Fixed priority up > down > left > right among asserted `db_x` gives `held_dir`, an encoding of NONE/UP/DOWN/LEFT/RIGHT. No diagonals.
- **Tap latch.**
  - A rising edge of any `db_x` records that direction in `pending_dir`. When several edges occur in one cycle, the priority winner is recorded.
  - A later edge overwrites `pending_dir`.
  - `pending_dir` clears on the tick that consumes it.
  - A tap longer than debounce but shorter than a frame therefore still yields exactly one move.
- **FSM.** States IDLE, FIRST and REPEAT, with frame counter `fcnt`. All transitions happen only on `tick`.
  - IDLE: if `pending_dir` or `held_dir` is not NONE, emit it (`pending_dir` preferred), go to FIRST, set `fcnt=0`. Otherwise emit NONE.
  - FIRST:
    - If `pending_dir` is not NONE and differs from the last emitted direction, emit it, stay in FIRST, set `fcnt=0`.
    - Else if `held_dir` is NONE, go to IDLE and emit NONE.
    - Else if `fcnt==FIRST_REPEAT_FRAMES-1`, emit `held_dir`, go to REPEAT, set `fcnt=0`.
    - Else increment `fcnt` and emit NONE.
  - REPEAT: same rules as FIRST, except the repeat threshold is `REPEAT_FRAMES-1` and the state stays in REPEAT on a repeat. A new-direction `pending_dir` returns the FSM to FIRST.
- **Emit.** Outputs register the one-hot decode of the emitted direction on `tick`. They hold that value until the next `tick`, so each command is high for exactly one frame period and is stable across the consumer's sampling tick.

## Timing

- **Reset.** Asserting `reset` low at any time, including mid-debounce or mid-repeat, immediately forces:
  - all outputs to 0;
  - FSM to IDLE;
  - `fcnt`, `pending_dir` and the debounce counters to 0;
  - `db_x` and the synchroniser flops to 0.
- **Release latency.** Movement resumes only after the release of `reset` plus a fresh debounced press.
- **Press latency.** 2 sync cycles + `DEBOUNCE_CYCLES` to `db_x`, then +1 cycle to `pending_dir`.
- **Command latency.**
  - The command asserts on the first `tick` after `pending_dir` sets, and `player_controller` acts on it at the following tick.
  - If `pending_dir` sets in the same cycle as a `tick`, it is seen at the next tick.
- **Repeat cadence.** For a continuous hold, commands are issued at ticks T, T+`FIRST_REPEAT_FRAMES`, then every `REPEAT_FRAMES` after that.
- **Release during FIRST or REPEAT.** No further commands. The FSM reaches IDLE at the next tick.
- **Counter range.** `fcnt` width is `$clog2(max(FIRST_REPEAT_FRAMES, REPEAT_FRAMES))` and never exceeds threshold−1.
- **Minimum parameter values.** `FIRST_REPEAT_FRAMES` and `REPEAT_FRAMES` must be ≥ 1. A value of 1 means a command on every tick.

## Structure

- Shared package `game_pkg`:
  - `typedef enum logic [2:0] {DIR_NONE, DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT} dir_t`, reused by `player_controller` and the map/collision logic;
  - `GRID_STEP = 16`.
- FSM state enum: local to this block.
- Sub-module `button_debouncer`: synchroniser, counter and `db` output with a `rise` strobe, parameterised by `DEBOUNCE_CYCLES`. Instantiated four times.

## Test plan

Run the bench with `DEBOUNCE_CYCLES=4`, `FIRST_REPEAT_FRAMES=3`, `REPEAT_FRAMES=2`, and a short frame model.

1. Bounce: `btn_up` toggles every 2 cycles for 20 cycles, then holds 0 → `db_up` stays 0 and no output is ever asserted.
2. Tap: `btn_left` high for 8 cycles mid-frame → `left` is high for exactly one frame, starting at the next tick. All other outputs stay 0.
3. Hold: `btn_right` held for 10 frames → `right` asserted at ticks T, T+3, T+5, T+7 and T+9, each for one frame.
4. Simultaneous press: `btn_up` and `btn_right` pressed in the same cycle → only `up` asserts. Releasing up while right is still held stops `up`, and `right` is then emitted at the next threshold or tick according to the FSM rules.
5. Direction change: hold `btn_down`, then after 1 frame tap `btn_left` → `left` is emitted at the next tick and `fcnt` restarts.
6. Reset mid-repeat: `reset` pulled low during REPEAT with `right` high → all outputs drop to 0 asynchronously and `busy` goes to 0. After release, still holding the button gives a new command only after the debounce delay.
